// File: rtl/basic_computer_pkg.sv
// Shared widths and opcode names for the basic-computer control unit.
package basic_computer_pkg;

    localparam int SC_WIDTH_DEF = 4;
    localparam int OP_WIDTH_DEF = 3;

    typedef enum logic [OP_WIDTH_DEF-1:0] {
        OP_AND    = 3'd0,
        OP_ADD    = 3'd1,
        OP_LDA    = 3'd2,
        OP_STA    = 3'd3,
        OP_BUN    = 3'd4,
        OP_BSA    = 3'd5,
        OP_ISZ    = 3'd6,
        OP_IO_REG = 3'd7
    } opcode_e;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational binary-to-one-hot decoder with enable.
module onehot_decoder #(
    parameter int IN_WIDTH = 4
) (
    input  logic [IN_WIDTH-1:0]      in,
    input  logic                     en,
    output logic [2**IN_WIDTH-1:0]   out
);

    always_comb begin
        out = '0;
        case (en)
            1'b1:    out[in] = 1'b1;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/seq_timing_decoder.sv
// Sequence counter with one-hot timing and latched-opcode decode.
module seq_timing_decoder
    import basic_computer_pkg::*;
#(
    parameter int SC_WIDTH = SC_WIDTH_DEF,
    parameter int OP_WIDTH = OP_WIDTH_DEF,
    parameter int T_LAST   = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sc_clr,
    input  logic                     sc_inc,
    input  logic                     op_ld,
    input  logic [OP_WIDTH-1:0]      op_in,
    output logic [SC_WIDTH-1:0]      sc_val,
    output logic [2**SC_WIDTH-1:0]   t_out,
    output logic [2**OP_WIDTH-1:0]   d_out,
    output logic                     op_valid,
    output logic                     wrap
);

    localparam logic [SC_WIDTH-1:0] SC_LAST = SC_WIDTH'(T_LAST);

    logic [SC_WIDTH-1:0] sc_q;
    logic                wrap_q;
    logic [OP_WIDTH-1:0] op_q;
    logic                opv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q   <= '0;
            wrap_q <= 1'b0;
        end else if (sc_clr) begin
            sc_q   <= '0;
            wrap_q <= 1'b0;
        end else if (sc_inc) begin
            if (sc_q == SC_LAST) begin
                sc_q   <= '0;
                wrap_q <= 1'b1;
            end else begin
                sc_q   <= sc_q + 1'b1;
                wrap_q <= 1'b0;
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    // Opcode latch runs independently of the SC controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            opv_q <= 1'b0;
        end else if (op_ld) begin
            op_q  <= op_in;
            opv_q <= 1'b1;
        end
    end

    onehot_decoder #(.IN_WIDTH(SC_WIDTH)) u_t_dec (
        .in  (sc_q),
        .en  (1'b1),
        .out (t_out)
    );

    onehot_decoder #(.IN_WIDTH(OP_WIDTH)) u_d_dec (
        .in  (op_q),
        .en  (opv_q),
        .out (d_out)
    );

    assign sc_val   = sc_q;
    assign wrap     = wrap_q;
    assign op_valid = opv_q;

endmodule

// File: tb/tb_seq_timing_decoder.sv
// Bench for seq_timing_decoder: T_LAST=15 vector table and T_LAST=4 sequence.
module tb_seq_timing_decoder;
    import basic_computer_pkg::*;

    typedef struct packed {
        logic [3:0]  sc;
        logic [15:0] t;
        logic [7:0]  d;
        logic        v;
        logic        w;
    } obs_t;

    typedef struct {
        logic       r;
        logic       c;
        logic       i;
        logic       l;
        logic [2:0] op;
        obs_t       e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b1, a_clr = 1'b0, a_inc = 1'b0, a_ld = 1'b0;
    logic [2:0]  a_op = '0;
    logic [3:0]  a_sc;
    logic [15:0] a_t;
    logic [7:0]  a_d;
    logic        a_v, a_w;

    logic        b_rst = 1'b1, b_clr = 1'b0, b_inc = 1'b0, b_ld = 1'b0;
    logic [2:0]  b_op = '0;
    logic [3:0]  b_sc;
    logic [15:0] b_t;
    logic [7:0]  b_d;
    logic        b_v, b_w;

    seq_timing_decoder #(.SC_WIDTH(4), .OP_WIDTH(3), .T_LAST(15)) dut_a (
        .clk(clk), .rst(a_rst), .sc_clr(a_clr), .sc_inc(a_inc),
        .op_ld(a_ld), .op_in(a_op), .sc_val(a_sc), .t_out(a_t),
        .d_out(a_d), .op_valid(a_v), .wrap(a_w)
    );

    seq_timing_decoder #(.SC_WIDTH(4), .OP_WIDTH(3), .T_LAST(4)) dut_b (
        .clk(clk), .rst(b_rst), .sc_clr(b_clr), .sc_inc(b_inc),
        .op_ld(b_ld), .op_in(b_op), .sc_val(b_sc), .t_out(b_t),
        .d_out(b_d), .op_valid(b_v), .wrap(b_w)
    );

    int   errors = 0;
    int   checks = 0;
    obs_t sb[$];
    vec_t vecs[$];

    function automatic obs_t mk(int sc, logic [7:0] d, logic v, logic w);
        obs_t o;
        o.sc = 4'(sc);
        o.t  = 16'(1) << sc;
        o.d  = d;
        o.v  = v;
        o.w  = w;
        return o;
    endfunction

    task automatic add(logic r, logic c, logic i, logic l, logic [2:0] op,
                       int sc, logic [7:0] d, logic v, logic w);
        vec_t x;
        x.r = r; x.c = c; x.i = i; x.l = l; x.op = op;
        x.e = mk(sc, d, v, w);
        vecs.push_back(x);
    endtask

    task automatic cmp(string name, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got sc=%0d t=%h d=%h v=%b w=%b, want sc=%0d t=%h d=%h v=%b w=%b",
                     name, act.sc, act.t, act.d, act.v, act.w,
                     exp.sc, exp.t, exp.d, exp.v, exp.w);
        end
    endtask

    task automatic pop_check(string name, obs_t act);
        obs_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            checks--;
            e = sb.pop_front();
            cmp(name, act, e);
        end
    endtask

    task automatic drive_a(vec_t x, int idx);
        @(negedge clk);
        a_rst = x.r; a_clr = x.c; a_inc = x.i; a_ld = x.l; a_op = x.op;
        sb.push_back(x.e);
        @(posedge clk);
        #1;
        pop_check($sformatf("a_vec%0d", idx), obs_t'({a_sc, a_t, a_d, a_v, a_w}));
    endtask

    int m_sc = 0;

    task automatic step_b(logic r, logic c, logic i, string name);
        logic w;
        @(negedge clk);
        b_rst = r; b_clr = c; b_inc = i; b_ld = 1'b0;
        w = 1'b0;
        if (r || c) m_sc = 0;
        else if (i) begin
            if (m_sc == 4) begin
                m_sc = 0;
                w = 1'b1;
            end else m_sc++;
        end
        sb.push_back(mk(m_sc, 8'h00, 1'b0, w));
        @(posedge clk);
        #1;
        pop_check(name, obs_t'({b_sc, b_t, b_d, b_v, b_w}));
        checks++;
        if (b_t[15:5] !== 11'd0) begin
            errors++;
            $display("FAIL %s_thi: got t_out[15:5]=%h, want 0", name, b_t[15:5]);
        end
    endtask

    initial begin
        // Reset twice
        add(1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        // Count through T_LAST and wrap
        for (int k = 1; k <= 15; k++) add(0, 0, 1, 0, 0, k, 8'h00, 0, 0);
        add(0, 0, 1, 0, 0, 0, 8'h00, 0, 1);
        add(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        // Clear beats increment at sc=7
        for (int k = 1; k <= 7; k++) add(0, 0, 1, 0, 0, k, 8'h00, 0, 0);
        add(0, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        add(0, 0, 1, 0, 0, 1, 8'h00, 0, 0);
        add(0, 0, 1, 0, 0, 2, 8'h00, 0, 0);
        // Opcode latch alongside increment
        add(0, 0, 1, 1, OP_BSA, 3, 8'h20, 1, 0);
        add(0, 0, 0, 0, OP_STA, 3, 8'h20, 1, 0);
        add(0, 0, 0, 1, OP_IO_REG, 3, 8'h80, 1, 0);
        // Clear with increment at T_LAST: no wrap
        for (int k = 4; k <= 15; k++) add(0, 0, 1, 0, 0, k, 8'h80, 1, 0);
        add(0, 1, 1, 0, 0, 0, 8'h80, 1, 0);
        add(0, 0, 0, 0, 0, 0, 8'h80, 1, 0);
        // Held load: last sample wins
        add(0, 0, 0, 1, OP_ADD, 0, 8'h02, 1, 0);
        add(0, 0, 0, 1, OP_ISZ, 0, 8'h40, 1, 0);
        // Reset at T_LAST with inc and load pending
        for (int k = 1; k <= 15; k++) add(0, 0, 1, 0, 0, k, 8'h40, 1, 0);
        add(1, 0, 1, 1, OP_LDA, 0, 8'h00, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);

        for (int n = 0; n < vecs.size(); n++) drive_a(vecs[n], n);

        step_b(1, 0, 0, "b_rst0");
        step_b(1, 0, 0, "b_rst1");
        for (int k = 0; k < 12; k++) step_b(0, 0, 1, $sformatf("b_inc%0d", k));
        while (m_sc != 4) step_b(0, 0, 1, "b_to_last");
        step_b(0, 1, 1, "b_clr_at_last");
        step_b(0, 0, 0, "b_hold");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d entries left, want 0", sb.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
